// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control interface.
// Bundles the debounced push-button inputs and the control/status outputs
// between the button conditioning side and the stopwatch datapath/LEDs.
//   btn_run_stop, btn_clear, btn_lap : debounced buttons (async to clk)
//   tick      : one-cycle count pulse at TICK_HZ while running
//   clear     : one-cycle pulse, counter must zero
//   lap_hold  : level, display freezes while 1
//   state_o   : current state (0 STOP, 1 RUN, 2 CLEAR)
//   led_run   : 1 while running
//   led_stop  : 1 while stopped
// master = button/datapath side, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if;
  logic       btn_run_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic       tick;
  logic       clear;
  logic       lap_hold;
  logic [1:0] state_o;
  logic       led_run;
  logic       led_stop;

  modport master (
    output btn_run_stop, btn_clear, btn_lap,
    input  tick, clear, lap_hold, state_o, led_run, led_stop
  );

  modport slave (
    input  btn_run_stop, btn_clear, btn_lap,
    output tick, clear, lap_hold, state_o, led_run, led_stop
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM.
// Conditions three debounced buttons (2-flop sync + rising-edge detect),
// sequences STOP/RUN/CLEAR, divides clk down to the count tick, and drives
// the clear pulse, lap-freeze level and status LEDs.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : stopwatch_ctrl_if.slave (buttons in, control/status out)
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic              clk,
  input  logic              reset,
  stopwatch_ctrl_if.slave   bus
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned PW   = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Button vector order: [0] run/stop, [1] clear, [2] lap
  logic [2:0]    btn;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    prev;
  logic [2:0]    press;
  state_t        state;
  logic [PW-1:0] prescaler;
  logic          lap_hold;

  assign btn = {bus.btn_lap, bus.btn_clear, bus.btn_run_stop};

  // press is registered so a button first sampled at edge k acts on the
  // FSM at edge k+3.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      press <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      press <= sync2 & ~prev;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_STOP;
      prescaler <= '0;
      lap_hold  <= 1'b0;
    end else begin
      case (state)
        ST_STOP: begin
          if (press[1])
            state <= ST_CLEAR;
          else if (press[0])
            state <= ST_RUN;
          if (press[2])
            lap_hold <= 1'b0;
        end
        ST_RUN: begin
          if (press[0])
            state <= ST_STOP;
          if (press[2])
            lap_hold <= ~lap_hold;
          if (prescaler == LAST)
            prescaler <= '0;
          else
            prescaler <= prescaler + PW'(1);
        end
        ST_CLEAR: begin
          state     <= ST_STOP;
          prescaler <= '0;
          lap_hold  <= 1'b0;
        end
        default: state <= ST_STOP;
      endcase
    end
  end

  assign bus.tick     = (state == ST_RUN) && (prescaler == LAST);
  assign bus.clear    = (state == ST_CLEAR);
  assign bus.lap_hold = lap_hold;
  assign bus.state_o  = state;
  assign bus.led_run  = (state == ST_RUN);
  assign bus.led_stop = (state == ST_STOP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=100 (DIV=10).
module tb_stopwatch_ctrl;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-edge press: 0 run/stop, 1 clear, 2 lap
  task automatic tap(input int which);
    case (which)
      0: bus.btn_run_stop = 1'b1;
      1: bus.btn_clear    = 1'b1;
      default: bus.btn_lap = 1'b1;
    endcase
    step(1);
    bus.btn_run_stop = 1'b0;
    bus.btn_clear    = 1'b0;
    bus.btn_lap      = 1'b0;
  endtask

  // Check tick per cycle: first tick in cycle 'first', then every 10 cycles.
  task automatic run_ticks(input string tag, input int n, input int first);
    for (int i = 1; i <= n; i++) begin
      check(tag, int'(bus.tick), (i >= first && ((i - first) % 10) == 0) ? 1 : 0);
      step(1);
    end
  endtask

  initial begin
    int cnt;
    int cnt2;
    reset = 1'b0;
    bus.btn_run_stop = 1'b0;
    bus.btn_clear    = 1'b0;
    bus.btn_lap      = 1'b0;

    // 1: reset
    step(3);
    check("rst_state", int'(bus.state_o), 0);
    check("rst_led_stop", int'(bus.led_stop), 1);
    check("rst_led_run", int'(bus.led_run), 0);
    check("rst_tick", int'(bus.tick), 0);
    check("rst_clear", int'(bus.clear), 0);
    check("rst_lap", int'(bus.lap_hold), 0);
    reset = 1'b1;
    step(1);
    check("idle_state", int'(bus.state_o), 0);

    // 2: 5-cycle run press, latency k+3, ticks every 10
    bus.btn_run_stop = 1'b1;
    step(3);
    check("run_lat_early", int'(bus.state_o), 0);
    step(1);
    check("run_entry", int'(bus.state_o), 1);
    check("run_led_run", int'(bus.led_run), 1);
    check("run_led_stop", int'(bus.led_stop), 0);
    cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      check("run_tick", int'(bus.tick), (i % 10 == 0) ? 1 : 0);
      if (bus.state_o != 2'd1) cnt++;
      step(1);
      if (i == 1) bus.btn_run_stop = 1'b0;
    end
    check("run_single_transition", cnt, 0);

    // 3: stop at prescaler 4, idle 50, resume -> tick after 6
    tap(0);
    step(2);
    check("stop_lat_early", int'(bus.state_o), 1);
    step(1);
    check("stop_entry", int'(bus.state_o), 0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cnt += int'(bus.tick);
      step(1);
    end
    tap(0);
    for (int i = 0; i < 3; i++) begin
      cnt += int'(bus.tick);
      step(1);
    end
    check("stop_no_tick", cnt, 0);
    check("resume_state", int'(bus.state_o), 1);
    run_ticks("resume_tick", 16, 6);

    // 4: clear + run together in STOP
    tap(0);
    step(3);
    check("stop2_state", int'(bus.state_o), 0);
    bus.btn_clear    = 1'b1;
    bus.btn_run_stop = 1'b1;
    step(1);
    bus.btn_clear    = 1'b0;
    bus.btn_run_stop = 1'b0;
    step(3);
    check("clr_state", int'(bus.state_o), 2);
    check("clr_pulse", int'(bus.clear), 1);
    check("clr_led_run", int'(bus.led_run), 0);
    check("clr_led_stop", int'(bus.led_stop), 0);
    step(1);
    check("clr_back_stop", int'(bus.state_o), 0);
    check("clr_pulse_end", int'(bus.clear), 0);
    cnt = 0;
    cnt2 = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.state_o != 2'd0) cnt++;
      cnt2 += int'(bus.clear);
      step(1);
    end
    check("clr_no_run", cnt, 0);
    check("clr_no_repulse", cnt2, 0);
    tap(0);
    step(3);
    check("post_clr_run", int'(bus.state_o), 1);
    run_ticks("post_clr_tick", 10, 10);

    // 5: lap toggling
    tap(2);
    step(2);
    check("lap_lat_early", int'(bus.lap_hold), 0);
    step(1);
    check("lap_on", int'(bus.lap_hold), 1);
    tap(2);
    step(3);
    check("lap_off", int'(bus.lap_hold), 0);
    tap(2);
    step(3);
    check("lap_on2", int'(bus.lap_hold), 1);
    tap(0);
    step(3);
    check("lap_stop_state", int'(bus.state_o), 0);
    check("lap_kept_in_stop", int'(bus.lap_hold), 1);
    tap(2);
    step(3);
    check("lap_cleared_in_stop", int'(bus.lap_hold), 0);
    check("lap_stop_stays", int'(bus.state_o), 0);

    // 6: clear ignored in RUN, then mid-run reset
    tap(0);
    step(3);
    check("r6_run", int'(bus.state_o), 1);
    tap(1);
    step(3);
    check("r6_clr_ignored", int'(bus.state_o), 1);
    cnt = 0;
    cnt2 = 0;
    for (int i = 0; i < 20; i++) begin
      cnt += int'(bus.tick);
      cnt2 += int'(bus.clear);
      step(1);
    end
    check("r6_ticks_continue", cnt, 2);
    check("r6_no_clear", cnt2, 0);
    tap(2);
    step(3);
    check("r6_lap_on", int'(bus.lap_hold), 1);
    step(3);
    reset = 1'b0;
    step(1);
    check("mrst_state", int'(bus.state_o), 0);
    check("mrst_lap", int'(bus.lap_hold), 0);
    check("mrst_led_stop", int'(bus.led_stop), 1);
    check("mrst_tick", int'(bus.tick), 0);
    reset = 1'b1;
    step(1);
    tap(0);
    step(3);
    check("mrst_run", int'(bus.state_o), 1);
    run_ticks("mrst_tick_prescaler0", 10, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
